// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ram_arb_pkg: shared types for the two-master data-RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int NUM_MASTERS = 2;
  localparam int TAGWIDTH    = $clog2(NUM_MASTERS);

endpackage
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------------
// ram_arbiter: round-robin two-master front end for ram_Controller.
// Optional ARB_LOCK_EN adds m1_lock bus locking.  Rev 1.0
// ------------------------------------------------------------------------
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int  DEPTH     = 4096,
  parameter int  XLEN      = 32,
  localparam int ADDRWIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [ADDRWIDTH-1:0] m0_addr,
  input  logic [XLEN-1:0]      m0_wdata,
  input  logic [1:0]           m0_size,
  input  logic                 m0_unsigned,
  output logic                 m0_gnt,
  output logic                 m0_rvalid,
  output logic [XLEN-1:0]      m0_rdata,

  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [ADDRWIDTH-1:0] m1_addr,
  input  logic [XLEN-1:0]      m1_wdata,
  input  logic [1:0]           m1_size,
  input  logic                 m1_unsigned,
`ifdef ARB_LOCK_EN
  input  logic                 m1_lock,
`endif
  output logic                 m1_gnt,
  output logic                 m1_rvalid,
  output logic [XLEN-1:0]      m1_rdata,

  output logic [ADDRWIDTH-1:0] ram_addr,
  output logic [XLEN-1:0]      ram_wrData,
  output logic                 ram_wrEn,
  output logic                 ram_rdEn,
  output logic                 ram_byteEn,
  output logic                 ram_halfEn,
  output logic                 ram_wordEn,
  output logic                 ram_unsignedEn,
  input  logic [XLEN-1:0]      ram_dataOut,
  input  logic                 ram_outEn
);

  logic                rLast;
  logic                rPend;
  logic [TAGWIDTH-1:0] rTag;

  logic       wLocked;
  logic       wAny;
  logic       wWin;
  logic       wGnt;
  logic       wSel;
  logic       wWe;
  logic [1:0] wSize;

`ifdef ARB_LOCK_EN
  arb_state_t rState;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rState <= ARB_IDLE;
    end else begin
      case (rState)
        ARB_IDLE:   if (m1_gnt && m1_lock) rState <= ARB_LOCKED;
        ARB_LOCKED: if (!m1_lock)          rState <= ARB_IDLE;
        default:                           rState <= ARB_IDLE;
      endcase
    end
  end

  assign wLocked = (rState == ARB_LOCKED);
`else
  assign wLocked = 1'b0;
`endif

  // Grants are held off while reset is asserted, even with requests pending.
  assign wAny = rst_n & (m0_req | m1_req);

  always_comb begin
    wWin = m1_req;
    if (wLocked && m1_req)    wWin = 1'b1;
    else if (m0_req && m1_req) wWin = ~rLast;
  end

  assign m0_gnt = wAny & ~wWin & ~wLocked;
  assign m1_gnt = wAny & wWin;
  assign wGnt   = m0_gnt | m1_gnt;
  assign wSel   = m1_gnt;

  assign wWe            = wSel ? m1_we       : m0_we;
  assign wSize          = wSel ? m1_size     : m0_size;
  assign ram_addr       = wSel ? m1_addr     : m0_addr;
  assign ram_wrData     = wSel ? m1_wdata    : m0_wdata;
  assign ram_unsignedEn = wSel ? m1_unsigned : m0_unsigned;

  assign ram_byteEn = (wSize == SZ_BYTE);
  assign ram_halfEn = (wSize == SZ_HALF);
  assign ram_wordEn = wSize[1];

  assign ram_wrEn = wGnt & wWe;
  assign ram_rdEn = wGnt & ~wWe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rLast <= 1'b1;
      rPend <= 1'b0;
      rTag  <= '0;
    end else begin
      if (wGnt)     rLast <= wSel;
      rPend <= ram_rdEn;
      if (ram_rdEn) rTag  <= wSel;
    end
  end

  // rPend masks a stale outEn from a read that was cut off by reset.
  assign m0_rvalid = ram_outEn & rPend & (rTag == TAGWIDTH'(0));
  assign m1_rvalid = ram_outEn & rPend & (rTag == TAGWIDTH'(1));
  assign m0_rdata  = m0_rvalid ? ram_dataOut : '0;
  assign m1_rdata  = m1_rvalid ? ram_dataOut : '0;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// tb_ram_arbiter: scoreboard bench with a behavioural ram_Controller stub.
module tb_ram_arbiter;

  localparam int DEPTH = 4096;
  localparam int XLEN  = 32;
  localparam int AW    = 12;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            dReq   [2];
  logic            dWe    [2];
  logic [AW-1:0]   dAddr  [2];
  logic [XLEN-1:0] dWdata [2];
  logic [1:0]      dSize  [2];
  logic            dUns   [2];

  logic            m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [XLEN-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0]   ram_addr;
  logic [XLEN-1:0] ram_wrData;
  logic [XLEN-1:0] ram_dataOut = '0;
  logic            ram_outEn   = 1'b0;
  logic            ram_wrEn, ram_rdEn, ram_byteEn, ram_halfEn, ram_wordEn, ram_unsignedEn;

  ram_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(dReq[0]), .m0_we(dWe[0]), .m0_addr(dAddr[0]), .m0_wdata(dWdata[0]),
    .m0_size(dSize[0]), .m0_unsigned(dUns[0]),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(dReq[1]), .m1_we(dWe[1]), .m1_addr(dAddr[1]), .m1_wdata(dWdata[1]),
    .m1_size(dSize[1]), .m1_unsigned(dUns[1]),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wrData(ram_wrData), .ram_wrEn(ram_wrEn), .ram_rdEn(ram_rdEn),
    .ram_byteEn(ram_byteEn), .ram_halfEn(ram_halfEn), .ram_wordEn(ram_wordEn),
    .ram_unsignedEn(ram_unsignedEn), .ram_dataOut(ram_dataOut), .ram_outEn(ram_outEn)
  );

  function automatic logic [31:0] initVal(logic [AW-1:0] a);
    if (a == 12'h010) return 32'h12345678;
    return (32'(a) * 32'h9E3779B1) ^ 32'hA5C30F1E;
  endfunction

  // Controller stub: flag-driven, not reset, 1-cycle read latency.
  logic [XLEN-1:0] stubMem [DEPTH];
  bit              stubWr  [DEPTH];
  logic [XLEN-1:0] stubCur;
  assign stubCur = stubWr[ram_addr] ? stubMem[ram_addr] : initVal(ram_addr);

  function automatic logic [31:0] stubExt(logic [31:0] w, logic b, logic h, logic u);
    if (b) return {{24{w[7] & ~u}}, w[7:0]};
    if (h) return {{16{w[15] & ~u}}, w[15:0]};
    return w;
  endfunction

  always @(posedge clk) begin
    ram_outEn <= ram_rdEn;
    if (ram_rdEn) ram_dataOut <= stubExt(stubCur, ram_byteEn, ram_halfEn, ram_unsignedEn);
    if (ram_wrEn) begin
      stubWr[ram_addr]  <= 1'b1;
      stubMem[ram_addr] <= ram_byteEn ? {stubCur[31:8], ram_wrData[7:0]} :
                           ram_halfEn ? {stubCur[31:16], ram_wrData[15:0]} : ram_wrData;
    end
  end

  // Reference model state
  logic [31:0] shadow [DEPTH];
  bit          mLast;
  bit          predG [2];
  typedef struct { int due; int m; logic [31:0] data; } exp_t;
  exp_t sbQ[$];
  exp_t monE;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nChecks = 0;
  int nFail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] modelRead(logic [31:0] w, logic [1:0] sz, logic uns);
    byte     sb;
    shortint sh;
    sb = w[7:0];
    sh = w[15:0];
    case (sz)
      2'b00:   return uns ? 32'(w[7:0])  : 32'(int'(sb));
      2'b01:   return uns ? 32'(w[15:0]) : 32'(int'(sh));
      default: return w;
    endcase
  endfunction

  task automatic modelWrite(logic [AW-1:0] a, logic [31:0] wd, logic [1:0] sz);
    case (sz)
      2'b00:   shadow[a] = (shadow[a] & 32'hFFFFFF00) | (wd & 32'h000000FF);
      2'b01:   shadow[a] = (shadow[a] & 32'hFFFF0000) | (wd & 32'h0000FFFF);
      default: shadow[a] = wd;
    endcase
  endtask

  task automatic predictAndCheck();
    int win;
    bit any;
    any = dReq[0] || dReq[1];
    // contested cycles go to whichever master did not win most recently
    if (dReq[0] && dReq[1]) win = mLast ? 0 : 1;
    else                    win = dReq[1] ? 1 : 0;
    predG[0] = any && (win == 0);
    predG[1] = any && (win == 1);
    chk("m0_gnt", 32'(m0_gnt), 32'(predG[0]));
    chk("m1_gnt", 32'(m1_gnt), 32'(predG[1]));
    if (any) begin
      chk("ram_wrEn", 32'(ram_wrEn), 32'(dWe[win]));
      chk("ram_rdEn", 32'(ram_rdEn), 32'(!dWe[win]));
      chk("ram_addr", 32'(ram_addr), 32'(dAddr[win]));
      chk("ram_sizeEn", {29'd0, ram_byteEn, ram_halfEn, ram_wordEn},
          dSize[win] == 2'b00 ? 32'd4 : dSize[win] == 2'b01 ? 32'd2 : 32'd1);
      chk("ram_unsignedEn", 32'(ram_unsignedEn), 32'(dUns[win]));
      if (dWe[win]) begin
        chk("ram_wrData", ram_wrData, dWdata[win]);
        modelWrite(dAddr[win], dWdata[win], dSize[win]);
      end else begin
        sbQ.push_back('{cyc + 1, win, modelRead(shadow[dAddr[win]], dSize[win], dUns[win])});
      end
      mLast = (win == 1);
    end else begin
      chk("idle ram_wrEn", 32'(ram_wrEn), 32'd0);
      chk("idle ram_rdEn", 32'(ram_rdEn), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (sbQ.size() > 0 && sbQ[0].due == cyc) begin
        monE = sbQ.pop_front();
        chk("m0_rvalid", 32'(m0_rvalid), 32'(monE.m == 0));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(monE.m == 1));
        chk("rdata", monE.m == 0 ? m0_rdata : m1_rdata, monE.data);
        chk("other rdata", monE.m == 0 ? m1_rdata : m0_rdata, 32'd0);
      end else begin
        chk("spurious rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
        chk("idle rdata", m0_rdata | m1_rdata, 32'd0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    predictAndCheck();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(int m, logic we, logic [AW-1:0] a, logic [31:0] wd,
                        logic [1:0] sz, logic u);
    dReq[m] = 1'b1; dWe[m] = we; dAddr[m] = a; dWdata[m] = wd; dSize[m] = sz; dUns[m] = u;
  endtask

  task automatic randReq(int m);
    setReq(m, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    dReq[m] = ($urandom_range(0, 3) != 0);
  endtask

  task automatic resetPulse();
    rst_n   = 1'b0;
    dReq[0] = 1'b0;
    dReq[1] = 1'b0;
    sbQ.delete();
    mLast   = 1'b1;
    #2;
    rst_n   = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < DEPTH; a++) shadow[a] = initVal(AW'(a));
    mLast = 1'b1;
    rst_n = 1'b0;
    for (int m = 0; m < 2; m++) setReq(m, 1'b0, '0, '0, 2'b10, 1'b0);

    // reset state with both masters requesting
    @(negedge clk);
    chk("reset m0_gnt", 32'(m0_gnt), 32'd0);
    chk("reset m1_gnt", 32'(m1_gnt), 32'd0);
    chk("reset ram_rdEn", 32'(ram_rdEn), 32'd0);
    chk("reset ram_wrEn", 32'(ram_wrEn), 32'd0);
    chk("reset rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
    chk("reset rdata", m0_rdata | m1_rdata, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dReq[0] = 1'b0;
    dReq[1] = 1'b0;

    // m0 word read of 0x010
    setReq(0, 1'b0, 12'h010, '0, 2'b10, 1'b0);
    step(); dReq[0] = 1'b0;
    step();

    // both masters contend for four cycles
    for (int i = 0; i < 4; i++) begin
      setReq(0, 1'b0, AW'(i), '0, 2'b10, 1'b0);
      setReq(1, 1'b0, AW'(i + 8), '0, 2'b01, 1'b1);
      step();
    end
    dReq[0] = 1'b0; dReq[1] = 1'b0;
    step();

    // m1 alone, so that m0 wins the following write/read contest
    setReq(1, 1'b1, 12'h100, 32'hCAFEF00D, 2'b10, 1'b0);
    step(); dReq[1] = 1'b0;
    setReq(0, 1'b1, 12'd5, 32'h000000AB, 2'b00, 1'b0);
    setReq(1, 1'b0, 12'd5, '0, 2'b00, 1'b0);
    step(); dReq[0] = 1'b0;
    step(); dReq[1] = 1'b0;
    step();

    // interleaved reads return to their issuers in order
    setReq(1, 1'b0, 12'd7, '0, 2'b10, 1'b0);
    step(); dReq[1] = 1'b0;
    setReq(0, 1'b0, 12'd8, '0, 2'b10, 1'b0);
    step(); dReq[0] = 1'b0;
    step();

    // reset pulse right after a read grant drops the response
    setReq(0, 1'b0, 12'h020, '0, 2'b10, 1'b0);
    step();
    resetPulse();
    step();
    setReq(0, 1'b0, 12'h030, '0, 2'b00, 1'b1);
    setReq(1, 1'b0, 12'h031, '0, 2'b10, 1'b0);
    step(); dReq[0] = 1'b0;
    step(); dReq[1] = 1'b0;
    step();

    predG[0] = 1'b0;
    predG[1] = 1'b0;
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++)
        if (!dReq[m] || predG[m] || $urandom_range(0, 7) == 0) randReq(m);
      step();
    end
    dReq[0] = 1'b0; dReq[1] = 1'b0;
    step();
    step();
    chk("scoreboard drained", 32'(sbQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
`default_nettype wire
